posit_quire_accum: RTL and testbench
====================================

Name: posit_quire_accum

Overview:
- Downstream consumer of the denormalized posit multiplier output.
- Accepts a stream of denormalized products (sign, scale, fraction, zero, NaR), framed into dot-product windows by sow/eow.
- Converts each product to a two's-complement fixed-point term and accumulates it exactly into a quire register.
- Emits one quire result per window, on the eow beat, for the downstream normalize/round stage.

Parameters:
POSIT_WIDTH, 16, posit word size of the source format.
POSIT_ES, 1, exponent size of the source format.
QUIRE_WIDTH, 128, total quire bits, two's complement.
QUIRE_FRAC_BITS, 64, quire bit index of weight 2^0 (LSB weight is 2^-QUIRE_FRAC_BITS).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rts_i  in  1  upstream ready to send
rtr_o  out  1  ready to receive (registered)
sow_i  in  1  first beat of window
eow_i  in  1  last beat of window
fraction_i  in  FW=GET_FRACTION_WIDTH(POSIT_WIDTH,POSIT_ES,1)  product fraction, hidden bit removed, MSB weight 2^-1
scale_i  in  SW=GET_SCALE_WIDTH(POSIT_WIDTH,POSIT_ES,1), signed  product scale
sign_i  in  1  product sign
zero_i  in  1  product is zero
NaR_i  in  1  product is NaR
rtr_i  in  1  downstream ready to receive
rts_o  out  1  result valid
sow_o  out  1  always 1 with rts_o (one-beat window)
eow_o  out  1  always 1 with rts_o
quire_o  out  QUIRE_WIDTH, signed  accumulated window sum
NaR_o  out  1  any term in window was NaR
zero_o  out  1  quire_o == 0 and not NaR_o
overflow_o  out  1  a term or the sum exceeded quire range in this window

Behaviour:
- Reset (async, rst_n=0): rtr_o=0, rts_o=0, sow_o=0, eow_o=0, quire_o=0, NaR_o=0, zero_o=0, overflow_o=0. Accumulator, sticky flags, skid register and stage-valid bits all 0. A reset mid-window discards the partial sum.
- Handshake:
  - Beat accepted when rts_i & rtr_o.
  - process_en = rtr_i | ~rts_o.
  - rtr_o <= process_en every cycle (one-cycle delayed).
  - Beat accepted while process_en=0 goes into a one-entry skid register. The skid entry is consumed before new input when process_en returns.
  - The whole pipeline stalls while process_en=0.
- Stage A (align), 1 cycle:
  - mag = {1, fraction_i}, value 1.f.
  - sh = scale + QUIRE_FRAC_BITS - FW.
  - sh >= 0: mag << sh. sh < 0: mag >> -sh, truncated toward zero.
  - Term overflow when scale >= QUIRE_WIDTH-1-QUIRE_FRAC_BITS: term forced to 0, term_ovf=1.
  - sign=1: term two's-complement negated.
  - zero_i or NaR_i: term = 0.
  - sow, eow, NaR and term_ovf are registered alongside the term.
- Stage B (accumulate), 1 cycle:
  - base = sow ? 0 : acc. sum = base + term.
  - Signed add overflow sets ovf. Sum wraps modulo 2^QUIRE_WIDTH.
  - nar_acc = (sow ? 0 : nar_acc) | NaR. ovf_acc is handled the same way, with term_ovf | add_ovf.
  - On eow: the output register loads sum, nar_acc and ovf_acc, and rts_o <= 1. acc, nar_acc and ovf_acc are cleared to 0.
  - NaR_o=1 forces quire_o=0.
- Latency: eow beat accepted at cycle t gives rts_o=1 at t+2 when unstalled.
- Output hold: rts_o and all outputs stay stable while rts_o & ~rtr_i. rts_o drops after transfer unless a new eow result is loaded the same cycle.
- Throughput: one beat per cycle. Back-to-back single-beat windows give one result per cycle.
- Framing boundaries:
  - sow & eow on the same beat: single-term window.
  - A beat without a preceding sow after an eow accumulates onto the cleared acc (implicit sow).
  - sow mid-window discards the previous partial sum.
  - Idle cycles inside a window keep acc unchanged.

Test Plan:
- Single-term window: sow=eow=1, sign=0, scale=0, fraction=0 -> at t+2 rts_o=1, quire_o=2^64, NaR_o=0, zero_o=0, overflow_o=0.
- Three-beat window: +1.0 (scale 0, frac 0); +1.5 (scale 0, fraction MSB only); -0.5 (sign 1, scale -1, frac 0) -> single result quire_o=2^65, no rts_o on the first two beats.
- Cancellation and NaR: window {+1.0, -1.0} -> quire_o=0, zero_o=1. Next window {+1.0, NaR, +2.0} -> NaR_o=1, quire_o=0. Following window {+1.0} -> quire_o=2^64, NaR_o=0.
- Range: scale=+70 -> overflow_o=1. scale=-70 with QUIRE_FRAC_BITS=64 -> term truncates to 0, quire_o=0, zero_o=1, overflow_o=0.
- Backpressure: 8 back-to-back single-term windows with rtr_i=0 for 5 cycles mid-stream -> rtr_o falls one cycle later, no beat lost or duplicated, 8 results in order, outputs stable while stalled.
- Reset mid-window: assert rst_n=0 after 2 beats, release, send {+1.0 eow} without sow -> all outputs 0 during reset, then quire_o=2^64.

Source files
------------

// File: rtl/posit_quire_accum_if.sv
// Stream interface between the posit multiplier (denormalized products) and the
// quire accumulator, plus the accumulator's result channel towards normalize/round.
interface posit_quire_accum_if #(
  parameter int FW = 25,
  parameter int SW = 8,
  parameter int QW = 128
);
  logic                 rts_i;
  logic                 rtr_o;
  logic                 sow_i;
  logic                 eow_i;
  logic [FW-1:0]        fraction_i;
  logic signed [SW-1:0] scale_i;
  logic                 sign_i;
  logic                 zero_i;
  logic                 NaR_i;

  logic                 rtr_i;
  logic                 rts_o;
  logic                 sow_o;
  logic                 eow_o;
  logic signed [QW-1:0] quire_o;
  logic                 NaR_o;
  logic                 zero_o;
  logic                 overflow_o;

  modport slave (
    input  rts_i, sow_i, eow_i, fraction_i, scale_i, sign_i, zero_i, NaR_i, rtr_i,
    output rtr_o, rts_o, sow_o, eow_o, quire_o, NaR_o, zero_o, overflow_o
  );

  modport master (
    output rts_i, sow_i, eow_i, fraction_i, scale_i, sign_i, zero_i, NaR_i, rtr_i,
    input  rtr_o, rts_o, sow_o, eow_o, quire_o, NaR_o, zero_o, overflow_o
  );
endinterface

// File: rtl/posit_quire_accum.sv
// Exact dot-product accumulator: aligns denormalized posit products into a
// two's-complement quire and emits one sum per sow/eow-framed window.
module posit_quire_accum #(
  parameter int POSIT_WIDTH     = 16,
  parameter int POSIT_ES        = 1,
  parameter int QUIRE_WIDTH     = 128,
  parameter int QUIRE_FRAC_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  posit_quire_accum_if.slave   bus
);

  function automatic int get_fraction_width(input int n, input int es, input int is_prod);
    int base;
    base = n - es - 32'sd3;
    return (is_prod != 32'sd0) ? (32'sd2 * base + 32'sd1) : base;
  endfunction

  function automatic int get_scale_width(input int n, input int es, input int is_prod);
    int base;
    base = $clog2((n - 32'sd2) << es) + 32'sd1;
    return (is_prod != 32'sd0) ? (base + 32'sd2) : base;
  endfunction

  localparam int FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, 32'sd1);
  localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, 32'sd1);
  localparam int QW = QUIRE_WIDTH;

  localparam logic signed [31:0] SH_OFS    = 32'(QUIRE_FRAC_BITS - FW);
  localparam logic signed [31:0] OVF_SCALE = 32'(QUIRE_WIDTH - 1 - QUIRE_FRAC_BITS);
  localparam logic [QW-1:0]      ONE_Q     = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0]      ZERO_Q    = {QW{1'b0}};

  typedef struct packed {
    logic                 sow;
    logic                 eow;
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
  } beat_t;

  logic              process_en_s;
  logic              accept_s;
  logic              stage_in_vld_s;
  beat_t             in_beat_s;
  beat_t             sel_beat_s;
  beat_t             skid_r;
  logic              skid_vld_r;
  logic              rtr_r;

  logic signed [31:0] scale_ext_s;
  logic signed [31:0] sh_s;
  logic [QW-1:0]      mag_s;
  logic [QW-1:0]      shifted_s;
  logic [QW-1:0]      term_mag_s;
  logic [QW-1:0]      term_s;
  logic               term_ovf_s;

  logic              a_vld_r;
  logic              a_sow_r;
  logic              a_eow_r;
  logic              a_nar_r;
  logic              a_ovf_r;
  logic [QW-1:0]     a_term_r;

  logic [QW-1:0]     base_s;
  logic [QW-1:0]     sum_s;
  logic              add_ovf_s;
  logic              nar_next_s;
  logic              ovf_next_s;

  logic [QW-1:0]     acc_r;
  logic              nar_acc_r;
  logic              ovf_acc_r;
  logic              rts_r;
  logic [QW-1:0]     quire_r;
  logic              nar_out_r;
  logic              zero_out_r;
  logic              ovf_out_r;

  assign process_en_s   = bus.rtr_i | ~rts_r;
  assign accept_s       = bus.rts_i & rtr_r;
  assign stage_in_vld_s = skid_vld_r | accept_s;
  assign sel_beat_s     = skid_vld_r ? skid_r : in_beat_s;

  // Pack the incoming beat so the skid entry and the live input share one shape
  always_comb begin
    in_beat_s       = '0;
    in_beat_s.sow   = bus.sow_i;
    in_beat_s.eow   = bus.eow_i;
    in_beat_s.sign  = bus.sign_i;
    in_beat_s.zero  = bus.zero_i;
    in_beat_s.nar   = bus.NaR_i;
    in_beat_s.scale = bus.scale_i;
    in_beat_s.frac  = bus.fraction_i;
  end

  assign scale_ext_s = {{(32-SW){sel_beat_s.scale[SW-1]}}, sel_beat_s.scale};
  assign sh_s        = scale_ext_s + SH_OFS;
  assign mag_s       = {{(QW-FW-1){1'b0}}, 1'b1, sel_beat_s.frac};

  // Align 1.f onto the quire grid; right shifts truncate bits below 2^-QUIRE_FRAC_BITS
  always_comb begin
    term_ovf_s = 1'b0;
    shifted_s  = ZERO_Q;
    term_mag_s = ZERO_Q;
    term_s     = ZERO_Q;
    if (sh_s[31]) begin
      shifted_s = mag_s >> (-sh_s);
    end else begin
      shifted_s = mag_s << sh_s;
    end
    // Zero and NaR carry no meaningful scale, so they never raise term overflow
    if (sel_beat_s.zero || sel_beat_s.nar) begin
      term_ovf_s = 1'b0;
      term_mag_s = ZERO_Q;
    end else if (scale_ext_s >= OVF_SCALE) begin
      term_ovf_s = 1'b1;
      term_mag_s = ZERO_Q;
    end else begin
      term_ovf_s = 1'b0;
      term_mag_s = shifted_s;
    end
    if (sel_beat_s.sign) begin
      term_s = (~term_mag_s) + ONE_Q;
    end else begin
      term_s = term_mag_s;
    end
  end

  // Input handshake, skid entry and the align stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_r      <= 1'b0;
      skid_vld_r <= 1'b0;
      skid_r     <= '0;
      a_vld_r    <= 1'b0;
      a_sow_r    <= 1'b0;
      a_eow_r    <= 1'b0;
      a_nar_r    <= 1'b0;
      a_ovf_r    <= 1'b0;
      a_term_r   <= ZERO_Q;
    end else begin
      rtr_r <= process_en_s;
      if (process_en_s) begin
        skid_vld_r <= 1'b0;
        a_vld_r    <= stage_in_vld_s;
        a_sow_r    <= sel_beat_s.sow;
        a_eow_r    <= sel_beat_s.eow;
        a_nar_r    <= sel_beat_s.nar;
        a_ovf_r    <= term_ovf_s;
        a_term_r   <= term_s;
      end else if (accept_s) begin
        skid_vld_r <= 1'b1;
        skid_r     <= in_beat_s;
      end
    end
  end

  // Accumulate with window restart on sow and signed overflow detection
  always_comb begin
    base_s     = a_sow_r ? ZERO_Q : acc_r;
    sum_s      = base_s + a_term_r;
    add_ovf_s  = (base_s[QW-1] == a_term_r[QW-1]) && (sum_s[QW-1] != base_s[QW-1]);
    nar_next_s = (a_sow_r ? 1'b0 : nar_acc_r) | a_nar_r;
    ovf_next_s = (a_sow_r ? 1'b0 : ovf_acc_r) | a_ovf_r | add_ovf_s;
  end

  // Accumulator, sticky flags and the held result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= ZERO_Q;
      nar_acc_r  <= 1'b0;
      ovf_acc_r  <= 1'b0;
      rts_r      <= 1'b0;
      quire_r    <= ZERO_Q;
      nar_out_r  <= 1'b0;
      zero_out_r <= 1'b0;
      ovf_out_r  <= 1'b0;
    end else if (process_en_s) begin
      rts_r <= a_vld_r & a_eow_r;
      if (a_vld_r && a_eow_r) begin
        acc_r      <= ZERO_Q;
        nar_acc_r  <= 1'b0;
        ovf_acc_r  <= 1'b0;
        quire_r    <= nar_next_s ? ZERO_Q : sum_s;
        nar_out_r  <= nar_next_s;
        zero_out_r <= ~nar_next_s & (sum_s == ZERO_Q);
        ovf_out_r  <= ovf_next_s;
      end else if (a_vld_r) begin
        acc_r      <= sum_s;
        nar_acc_r  <= nar_next_s;
        ovf_acc_r  <= ovf_next_s;
      end
    end
  end

  assign bus.rtr_o      = rtr_r;
  assign bus.rts_o      = rts_r;
  assign bus.sow_o      = rts_r;
  assign bus.eow_o      = rts_r;
  assign bus.quire_o    = quire_r;
  assign bus.NaR_o      = nar_out_r;
  assign bus.zero_o     = zero_out_r;
  assign bus.overflow_o = ovf_out_r;

endmodule

// File: tb/tb_posit_quire_accum.sv
// Directed scoreboard bench for posit_quire_accum: the driver queues expected
// window results on each accepted eow beat, a negedge monitor pops and compares.
module tb_posit_quire_accum;
  localparam int FW = 25;
  localparam int SW = 8;
  localparam int QW = 128;

  typedef struct packed {
    logic [QW-1:0] q;
    logic          nar;
    logic          zero;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  posit_quire_accum_if #(.FW(FW), .SW(SW), .QW(QW)) qif ();

  posit_quire_accum #(
    .POSIT_WIDTH(16), .POSIT_ES(1), .QUIRE_WIDTH(128), .QUIRE_FRAC_BITS(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (qif)
  );

  res_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   pushed = 0;
  int   seen   = 0;

  function automatic logic [QW-1:0] pw2(input int k);
    logic [QW-1:0] v;
    v = {{(QW-1){1'b0}}, 1'b1};
    return v << k;
  endfunction

  task automatic chk_q(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input bit sow, input bit eow, input bit sg, input bit zr, input bit nr,
                      input int sc, input logic [FW-1:0] fr);
    int n;
    n = 0;
    @(negedge clk);
    qif.rts_i      = 1'b1;
    qif.sow_i      = sow;
    qif.eow_i      = eow;
    qif.sign_i     = sg;
    qif.zero_i     = zr;
    qif.NaR_i      = nr;
    qif.scale_i    = SW'(sc);
    qif.fraction_i = fr;
    while (!qif.rtr_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!qif.rtr_o) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: rtr_o stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    qif.rts_i = 1'b0;
    qif.sow_i = 1'b0;
    qif.eow_i = 1'b0;
  endtask

  task automatic push(input logic [QW-1:0] q, input logic nar, input logic zero, input logic ovf);
    res_t r;
    r.q = q; r.nar = nar; r.zero = zero; r.ovf = ovf;
    exp_q.push_back(r);
    pushed++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_i("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_rtr_o"}, qif.rtr_o, 1'b0);
    chk_b({tag, "_rts_o"}, qif.rts_o, 1'b0);
    chk_b({tag, "_sow_o"}, qif.sow_o, 1'b0);
    chk_b({tag, "_eow_o"}, qif.eow_o, 1'b0);
    chk_q({tag, "_quire_o"}, qif.quire_o, '0);
    chk_b({tag, "_NaR_o"}, qif.NaR_o, 1'b0);
    chk_b({tag, "_zero_o"}, qif.zero_o, 1'b0);
    chk_b({tag, "_overflow_o"}, qif.overflow_o, 1'b0);
  endtask

  // Monitor: compare each transferred result against the scoreboard, check hold while stalled
  res_t hold_v;
  bit   stalled = 1'b0;
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk_b("hold_rts_o", qif.rts_o, 1'b1);
        chk_q("hold_quire_o", qif.quire_o, hold_v.q);
        chk_b("hold_NaR_o", qif.NaR_o, hold_v.nar);
        chk_b("hold_zero_o", qif.zero_o, hold_v.zero);
        chk_b("hold_overflow_o", qif.overflow_o, hold_v.ovf);
      end
      if (qif.rts_o && qif.rtr_i) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: quire_o %0h with no expected result queued", qif.quire_o);
        end else begin
          e = exp_q.pop_front();
          seen++;
          chk_q("res_quire_o", qif.quire_o, e.q);
          chk_b("res_NaR_o", qif.NaR_o, e.nar);
          chk_b("res_zero_o", qif.zero_o, e.zero);
          chk_b("res_overflow_o", qif.overflow_o, e.ovf);
          chk_b("res_sow_o", qif.sow_o, 1'b1);
          chk_b("res_eow_o", qif.eow_o, 1'b1);
        end
      end else if (qif.rts_o) begin
        stalled     = 1'b1;
        hold_v.q    = qif.quire_o;
        hold_v.nar  = qif.NaR_o;
        hold_v.zero = qif.zero_o;
        hold_v.ovf  = qif.overflow_o;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    qif.rts_i = 1'b0; qif.sow_i = 1'b0; qif.eow_i = 1'b0;
    qif.sign_i = 1'b0; qif.zero_i = 1'b0; qif.NaR_i = 1'b0;
    qif.scale_i = '0; qif.fraction_i = '0;
    qif.rtr_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-term window +1.0 with latency check
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    push(pw2(64), 1'b0, 1'b0, 1'b0);
    idle();
    chk_b("latency_t1_rts_o", qif.rts_o, 1'b0);
    @(negedge clk);
    chk_b("latency_t2_rts_o", qif.rts_o, 1'b1);
    repeat (2) @(negedge clk);

    // +1.0 + 1.5 - 0.5 = 2.0
    send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 25'h1000000);
    send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, 25'h0);
    push(pw2(65), 1'b0, 1'b0, 1'b0);

    // Cancellation, NaR window, then a clean window
    send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 25'h0);
    push('0, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    send(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 25'h0);
    send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 25'h0);
    push('0, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    push(pw2(64), 1'b0, 1'b0, 1'b0);

    // Range: term overflow and underflow truncation
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 70, 25'h0);
    push('0, 1'b0, 1'b1, 1'b1);
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -70, 25'h0);
    push('0, 1'b0, 1'b1, 1'b0);
    idle();
    drain();

    // Backpressure: 8 single-term windows with a 5-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, k, 25'h0);
          push(pw2(64 + k), 1'b0, 1'b0, 1'b0);
        end
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        qif.rtr_i = 1'b0;
        chk_b("stall_rtr_o_before", qif.rtr_o, 1'b1);
        @(posedge clk);
        #2;
        chk_b("stall_rtr_o_fall", qif.rtr_o, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        qif.rtr_i = 1'b1;
      end
    join
    drain();

    // Reset mid-window discards the partial sum
    send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    idle();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 25'h0);
    push(pw2(64), 1'b0, 1'b0, 1'b0);
    idle();
    drain();
    repeat (3) @(negedge clk);

    chk_i("results_seen", seen, pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
